// File: rtl/ant_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ant_motion_sequencer
// Desc   : Arbitrates nav/manual one-step motion commands and drives timed
//          left/right wheel codes, pulsing fsm_step once per completed nav move.
// Rev    : 1.0
// ============================================================================
module ant_motion_sequencer #(
  parameter int TICK_DIV   = 1000,
  parameter int TURN_STEPS = 4,
  parameter int FWD_STEPS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nav_req,
  input  logic       nav_tl,
  input  logic       nav_tr,
  input  logic       nav_f,
  output logic       nav_ack,
  input  logic       man_req,
  input  logic [1:0] man_cmd,
  output logic       man_ack,
  output logic [1:0] wheel_l,
  output logic [1:0] wheel_r,
  output logic       fsm_step,
  output logic       busy,
  output logic       src,
  output logic       err
);

  localparam int MAX_STEPS = (TURN_STEPS > FWD_STEPS) ? TURN_STEPS : FWD_STEPS;
  localparam int TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW        = $clog2(MAX_STEPS + 1);

  localparam logic [1:0]    C_IDLE      = 2'd0;
  localparam logic [1:0]    C_RUN       = 2'd1;
  localparam logic [1:0]    C_DONE      = 2'd2;
  localparam logic [1:0]    C_STOP      = 2'b00;
  localparam logic [1:0]    C_FWD       = 2'b01;
  localparam logic [1:0]    C_REV       = 2'b10;
  localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] C_TURN_N    = SW'(TURN_STEPS);
  localparam logic [SW-1:0] C_FWD_N     = SW'(FWD_STEPS);
  localparam logic [SW-1:0] C_ONE       = SW'(1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    mcnt_q, mcnt_d;
  logic          src_q, src_d;
  logic [1:0]    wheel_l_q, wheel_l_d;
  logic [1:0]    wheel_r_q, wheel_r_d;
  logic          nav_ack_q, nav_ack_d;
  logic          man_ack_q, man_ack_d;
  logic          err_q, err_d;
  logic          fsm_step_q, fsm_step_d;
  logic          busy_q, busy_d;

  logic          w_grant_man, w_grant_nav, w_preempt, w_last;
  logic          w_nav_err;
  logic [1:0]    w_nav_l, w_nav_r, w_man_l, w_man_r, w_cmd_l, w_cmd_r;
  logic [SW-1:0] w_nav_steps, w_man_steps, w_cmd_steps;

  // Manual wins ties unless it has starved a waiting nav request three times.
  always_comb begin
    w_grant_man = 1'b0;
    w_grant_nav = 1'b0;
    if (state_q == C_IDLE) begin
      if (man_req && !(nav_req && (mcnt_q == 2'd3))) begin
        w_grant_man = 1'b1;
      end else if (nav_req) begin
        w_grant_nav = 1'b1;
      end
    end
  end

  always_comb begin
    w_nav_l     = C_STOP;
    w_nav_r     = C_STOP;
    w_nav_steps = C_ONE;
    w_nav_err   = 1'b0;
    case ({nav_tl, nav_tr, nav_f})
      3'b001:  begin w_nav_l = C_FWD;  w_nav_r = C_FWD;  w_nav_steps = C_FWD_N;  end
      3'b100:  begin w_nav_l = C_REV;  w_nav_r = C_FWD;  w_nav_steps = C_TURN_N; end
      3'b010:  begin w_nav_l = C_FWD;  w_nav_r = C_REV;  w_nav_steps = C_TURN_N; end
      3'b101:  begin w_nav_l = C_STOP; w_nav_r = C_FWD;  w_nav_steps = C_TURN_N; end
      3'b011:  begin w_nav_l = C_FWD;  w_nav_r = C_STOP; w_nav_steps = C_TURN_N; end
      3'b110,
      3'b111:  w_nav_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_man_l     = C_STOP;
    w_man_r     = C_STOP;
    w_man_steps = C_ONE;
    case (man_cmd)
      2'b01:   begin w_man_l = C_FWD; w_man_r = C_FWD; w_man_steps = C_FWD_N;  end
      2'b10:   begin w_man_l = C_REV; w_man_r = C_FWD; w_man_steps = C_TURN_N; end
      2'b11:   begin w_man_l = C_FWD; w_man_r = C_REV; w_man_steps = C_TURN_N; end
      default: ;
    endcase
  end

  assign w_cmd_l     = w_grant_man ? w_man_l     : w_nav_l;
  assign w_cmd_r     = w_grant_man ? w_man_r     : w_nav_r;
  assign w_cmd_steps = w_grant_man ? w_man_steps : w_nav_steps;

  assign w_preempt = (state_q == C_RUN) && !src_q && man_req && (man_cmd == 2'b00);
  assign w_last    = (tick_q == C_TICK_LAST) && (step_q == C_ONE);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= C_IDLE;
      tick_q     <= '0;
      step_q     <= '0;
      mcnt_q     <= 2'd0;
      src_q      <= 1'b0;
      wheel_l_q  <= C_STOP;
      wheel_r_q  <= C_STOP;
      nav_ack_q  <= 1'b0;
      man_ack_q  <= 1'b0;
      err_q      <= 1'b0;
      fsm_step_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      step_q     <= step_d;
      mcnt_q     <= mcnt_d;
      src_q      <= src_d;
      wheel_l_q  <= wheel_l_d;
      wheel_r_q  <= wheel_r_d;
      nav_ack_q  <= nav_ack_d;
      man_ack_q  <= man_ack_d;
      err_q      <= err_d;
      fsm_step_q <= fsm_step_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; preemption takes priority over a simultaneous last-step wrap.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    step_d  = step_q;
    src_d   = src_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      C_IDLE: begin
        if (w_grant_man || w_grant_nav) begin
          state_d = C_RUN;
          tick_d  = '0;
          step_d  = w_cmd_steps;
          src_d   = w_grant_man;
          if (w_grant_nav) begin
            mcnt_d = 2'd0;
          end else if (nav_req) begin
            mcnt_d = mcnt_q + 2'd1;
          end
        end
      end
      C_RUN: begin
        if (w_preempt || w_last) begin
          state_d = C_DONE;
          tick_d  = '0;
          step_d  = '0;
        end else if (tick_q == C_TICK_LAST) begin
          tick_d = '0;
          step_d = step_q - C_ONE;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Output logic, registered so no input reaches an output combinationally.
  always_comb begin
    wheel_l_d  = C_STOP;
    wheel_r_d  = C_STOP;
    nav_ack_d  = 1'b0;
    man_ack_d  = 1'b0;
    err_d      = 1'b0;
    fsm_step_d = 1'b0;
    busy_d     = (state_d != C_IDLE);
    case (state_q)
      C_IDLE: begin
        nav_ack_d = w_grant_nav;
        man_ack_d = w_grant_man;
        err_d     = w_grant_nav && w_nav_err;
        if (state_d == C_RUN) begin
          wheel_l_d = w_cmd_l;
          wheel_r_d = w_cmd_r;
        end
      end
      C_RUN: begin
        if (state_d == C_RUN) begin
          wheel_l_d = wheel_l_q;
          wheel_r_d = wheel_r_q;
        end else begin
          fsm_step_d = !w_preempt && !src_q;
        end
      end
      default: ;
    endcase
  end

  assign nav_ack  = nav_ack_q;
  assign man_ack  = man_ack_q;
  assign wheel_l  = wheel_l_q;
  assign wheel_r  = wheel_r_q;
  assign fsm_step = fsm_step_q;
  assign busy     = busy_q;
  assign src      = src_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ant_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ant_motion_sequencer
// Desc   : Directed scenarios plus randomized traffic against a cycle-count model.
// Rev    : 1.0
// ============================================================================
module tb_ant_motion_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int TURN_STEPS = 4;
  localparam int FWD_STEPS  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nav_req = 1'b0, nav_tl = 1'b0, nav_tr = 1'b0, nav_f = 1'b0;
  logic       man_req = 1'b0;
  logic [1:0] man_cmd = 2'b00;
  logic       nav_ack, man_ack, fsm_step, busy, src, err;
  logic [1:0] wheel_l, wheel_r;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0 idle, 1 running, 2 done; run measured in cycles left.
  int         m_mode = 0, m_left = 0, m_mcnt = 0;
  logic       e_nav_ack = 0, e_man_ack = 0, e_fsm = 0, e_busy = 0, e_src = 0, e_err = 0;
  logic [1:0] e_wl = 0, e_wr = 0;

  ant_motion_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .TURN_STEPS(TURN_STEPS),
    .FWD_STEPS (FWD_STEPS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .nav_req (nav_req),
    .nav_tl  (nav_tl),
    .nav_tr  (nav_tr),
    .nav_f   (nav_f),
    .nav_ack (nav_ack),
    .man_req (man_req),
    .man_cmd (man_cmd),
    .man_ack (man_ack),
    .wheel_l (wheel_l),
    .wheel_r (wheel_r),
    .fsm_step(fsm_step),
    .busy    (busy),
    .src     (src),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nav_dec(input logic tl, input logic tr, input logic f,
                         output logic [1:0] l, output logic [1:0] r,
                         output int s, output logic e);
    l = 2'b00; r = 2'b00; s = 1; e = 1'b0;
    case ({tl, tr, f})
      3'b001: begin l = 2'b01; r = 2'b01; s = FWD_STEPS;  end
      3'b100: begin l = 2'b10; r = 2'b01; s = TURN_STEPS; end
      3'b010: begin l = 2'b01; r = 2'b10; s = TURN_STEPS; end
      3'b101: begin l = 2'b00; r = 2'b01; s = TURN_STEPS; end
      3'b011: begin l = 2'b01; r = 2'b00; s = TURN_STEPS; end
      3'b110, 3'b111: e = 1'b1;
      default: ;
    endcase
  endtask

  task automatic man_dec(input logic [1:0] c, output logic [1:0] l,
                         output logic [1:0] r, output int s);
    l = 2'b00; r = 2'b00; s = 1;
    case (c)
      2'b01: begin l = 2'b01; r = 2'b01; s = FWD_STEPS;  end
      2'b10: begin l = 2'b10; r = 2'b01; s = TURN_STEPS; end
      2'b11: begin l = 2'b01; r = 2'b10; s = TURN_STEPS; end
      default: ;
    endcase
  endtask

  // Advances the model by one clock edge, using the inputs present at that edge.
  task automatic model_step();
    logic [1:0] l, r;
    int         s;
    logic       e, man_wins, pre;
    e_nav_ack = 0; e_man_ack = 0; e_fsm = 0; e_err = 0;
    if (!rst) begin
      m_mode = 0; m_left = 0; m_mcnt = 0;
      e_wl = 0; e_wr = 0; e_busy = 0; e_src = 0;
    end else if (m_mode == 0) begin
      man_wins = man_req && !(nav_req && m_mcnt == 3);
      if (man_wins) begin
        man_dec(man_cmd, l, r, s);
        e_man_ack = 1; e_src = 1;
        if (nav_req) m_mcnt = m_mcnt + 1;
        e_wl = l; e_wr = r; m_left = s * TICK_DIV; m_mode = 1; e_busy = 1;
      end else if (nav_req) begin
        nav_dec(nav_tl, nav_tr, nav_f, l, r, s, e);
        e_nav_ack = 1; e_src = 0; m_mcnt = 0; e_err = e;
        e_wl = l; e_wr = r; m_left = s * TICK_DIV; m_mode = 1; e_busy = 1;
      end else begin
        e_wl = 0; e_wr = 0; e_busy = 0;
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      pre = (e_src == 0) && man_req && (man_cmd == 2'b00);
      if (pre || m_left == 0) begin
        m_mode = 2; e_wl = 0; e_wr = 0;
        e_fsm = !pre && (e_src == 0);
      end
    end else begin
      m_mode = 0; e_busy = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; nav_req = 0; man_req = 0; man_cmd = 2'b00;
    nav_tl = 0; nav_tr = 0; nav_f = 0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0; nav_req = 0; man_req = 0;
    cyc();
    checks++;
    if ({nav_ack, man_ack, wheel_l, wheel_r, fsm_step, busy, src, err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {nav_ack, man_ack, wheel_l, wheel_r, fsm_step, busy, src, err}, 10'd0);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_nav_f();
    do_reset();
    nav_req = 1; nav_tl = 0; nav_tr = 0; nav_f = 1;
    cyc();
    checks++;
    if ({nav_ack, man_ack, src} !== 3'b100) begin
      errors++; $display("FAIL navf_ack: got %b want 100", {nav_ack, man_ack, src});
    end
    nav_req = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) cyc();
      checks++;
      if ({wheel_l, wheel_r, busy, fsm_step} !== 6'b0101_1_0) begin
        errors++; $display("FAIL navf_run c%0d: got %b want 010110", c, {wheel_l, wheel_r, busy, fsm_step});
      end
    end
    cyc();
    checks++;
    if ({wheel_l, wheel_r, fsm_step, busy, nav_ack} !== 7'b0000_1_1_0) begin
      errors++; $display("FAIL navf_done: got %b want 0000110", {wheel_l, wheel_r, fsm_step, busy, nav_ack});
    end
    cyc();
    checks++;
    if ({busy, fsm_step, wheel_l, wheel_r} !== 6'd0) begin
      errors++; $display("FAIL navf_idle: got %b want 000000", {busy, fsm_step, wheel_l, wheel_r});
    end
  endtask

  task automatic test_tl_f();
    int steps = 0;
    do_reset();
    nav_req = 1; nav_tl = 1; nav_tr = 0; nav_f = 1;
    cyc();
    nav_req = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) cyc();
      if (fsm_step) steps++;
      checks++;
      if ({wheel_l, wheel_r, src, busy} !== 6'b0001_0_1) begin
        errors++; $display("FAIL tlf_run c%0d: got %b want 000101", c, {wheel_l, wheel_r, src, busy});
      end
    end
    for (int c = 17; c <= 19; c++) begin
      cyc();
      if (fsm_step) steps++;
      if (c == 17) begin
        checks++;
        if ({fsm_step, wheel_l, wheel_r} !== 5'b1_0000) begin
          errors++; $display("FAIL tlf_done: got %b want 10000", {fsm_step, wheel_l, wheel_r});
        end
      end
    end
    checks++;
    if (steps != 1) begin
      errors++; $display("FAIL tlf_step_count: got %0d want 1", steps);
    end
  endtask

  task automatic test_err();
    do_reset();
    nav_req = 1; nav_tl = 1; nav_tr = 1; nav_f = 1'($urandom_range(0, 1));
    cyc();
    nav_req = 0;
    checks++;
    if ({err, nav_ack, wheel_l, wheel_r, busy} !== 7'b1_1_0000_1) begin
      errors++; $display("FAIL err_first: got %b want 1100001", {err, nav_ack, wheel_l, wheel_r, busy});
    end
    for (int c = 2; c <= 4; c++) begin
      cyc();
      checks++;
      if ({err, wheel_l, wheel_r, busy, fsm_step} !== 7'b0_0000_1_0) begin
        errors++; $display("FAIL err_run c%0d: got %b want 0000010", c, {err, wheel_l, wheel_r, busy, fsm_step});
      end
    end
    cyc();
    checks++;
    if ({fsm_step, busy} !== 2'b11) begin
      errors++; $display("FAIL err_step: got %b want 11", {fsm_step, busy});
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, last_t = 0;
    do_reset();
    nav_req = 1; nav_tl = 0; nav_tr = 0; nav_f = 1;
    man_req = 1; man_cmd = 2'b01;
    for (int t = 1; t <= 200 && n < 8; t++) begin
      cyc();
      if (nav_ack || man_ack) begin
        checks++;
        if ((n % 4 == 3) ? ({nav_ack, man_ack} !== 2'b10) : ({nav_ack, man_ack} !== 2'b01)) begin
          errors++; $display("FAIL arb_grant %0d: got nav/man %b want %b", n,
                             {nav_ack, man_ack}, (n % 4 == 3) ? 2'b10 : 2'b01);
        end
        if (n > 0) begin
          checks++;
          if (t - last_t != TICK_DIV * FWD_STEPS + 2) begin
            errors++; $display("FAIL arb_spacing %0d: got %0d want %0d", n, t - last_t, TICK_DIV * FWD_STEPS + 2);
          end
        end
        last_t = t;
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL arb_timeout: got %0d grants want 8", n);
    end
    nav_req = 0; man_req = 0;
  endtask

  task automatic test_preempt();
    int steps = 0;
    do_reset();
    nav_req = 1; nav_tl = 0; nav_tr = 1; nav_f = 0;
    cyc();
    nav_req = 0;
    repeat (4) cyc();
    checks++;
    if ({wheel_l, wheel_r, busy} !== 5'b0110_1) begin
      errors++; $display("FAIL pre_run: got %b want 01101", {wheel_l, wheel_r, busy});
    end
    man_req = 1; man_cmd = 2'b00;
    cyc();
    checks++;
    if ({wheel_l, wheel_r, fsm_step, busy, man_ack} !== 7'b0000_0_1_0) begin
      errors++; $display("FAIL pre_done: got %b want 0000010", {wheel_l, wheel_r, fsm_step, busy, man_ack});
    end
    cyc();
    checks++;
    if ({busy, man_ack, fsm_step} !== 3'b000) begin
      errors++; $display("FAIL pre_idle: got %b want 000", {busy, man_ack, fsm_step});
    end
    cyc();
    checks++;
    if ({man_ack, src, wheel_l, wheel_r, busy} !== 7'b1_1_0000_1) begin
      errors++; $display("FAIL pre_man_ack: got %b want 1100001", {man_ack, src, wheel_l, wheel_r, busy});
    end
    man_req = 0;
    for (int c = 9; c <= 13; c++) begin
      cyc();
      if (fsm_step) steps++;
    end
    checks++;
    if (steps != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL pre_no_step: got steps %0d busy %b want 0 0", steps, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    nav_req = 1; nav_tl = 1; nav_tr = 0; nav_f = 0;
    cyc();
    nav_req = 0;
    cyc(); cyc();
    rst = 0; nav_req = 1; nav_tl = 0; nav_f = 1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if ({nav_ack, man_ack, wheel_l, wheel_r, fsm_step, busy, src, err} !== 10'd0) begin
        errors++; $display("FAIL midrst_out %0d: got %b want 0", k,
                           {nav_ack, man_ack, wheel_l, wheel_r, fsm_step, busy, src, err});
      end
    end
    rst = 1;
    cyc();
    checks++;
    if ({nav_ack, wheel_l, wheel_r, busy} !== 6'b1_0101_1) begin
      errors++; $display("FAIL midrst_regrant: got %b want 101011", {nav_ack, wheel_l, wheel_r, busy});
    end
    nav_req = 0;
  endtask

  task automatic test_random();
    logic [9:0] got, want;
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc();
      got  = {nav_ack, man_ack, wheel_l, wheel_r, fsm_step, busy, src, err};
      want = {e_nav_ack, e_man_ack, e_wl, e_wr, e_fsm, e_busy, e_src, e_err};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random cyc %0d: got %b want %b", t, got, want);
      end
      if (e_nav_ack) nav_req = 0;
      else if (!nav_req) begin
        if ($urandom_range(0, 2) == 0) begin
          nav_req = 1; {nav_tl, nav_tr, nav_f} = 3'($urandom);
        end
      end else if ($urandom_range(0, 39) == 0) nav_req = 0;
      if (e_man_ack) man_req = 0;
      else if (!man_req) begin
        if ($urandom_range(0, 5) == 0) begin
          man_req = 1; man_cmd = 2'($urandom);
        end
      end else if ($urandom_range(0, 39) == 0) man_req = 0;
    end
    nav_req = 0; man_req = 0; rst = 1;
  endtask

  initial begin
    test_reset();
    test_nav_f();
    test_tl_f();
    test_err();
    test_back_to_back();
    test_preempt();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ant_motion_sequencer.md
# ant_motion_sequencer

Motion sequencer between the RoboAnt navigation FSM and the wheel drivers. Accepts one-step turn/forward commands from two requesters, the navigation FSM (TL/TR/F) and a manual/host port, arbitrates between them, and converts the granted command into timed left/right wheel drive. Issues a one-cycle `fsm_step` enable so the navigation FSM advances exactly once per completed move.

## Interface
- `TICK_DIV`, default 1000: clk cycles per motion step, ≥2.
- `TURN_STEPS`, default 4: steps per turn or arc command, ≥1.
- `FWD_STEPS`, default 2: steps per straight-forward command, ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `nav_req`  in  1  navigation FSM requests a move. Level; held until `nav_ack`.
- `nav_tl`, `nav_tr`, `nav_f`  in  1 each  navigation command bits.
- `nav_ack`  out  1  one-cycle grant pulse to the navigation FSM.
- `man_req`  in  1  manual port requests a move. Level; held until `man_ack`.
- `man_cmd`  in  2  manual command: 00 stop, 01 forward, 10 spin left, 11 spin right.
- `man_ack`  out  1  one-cycle grant pulse to the manual port.
- `wheel_l`, `wheel_r`  out  2 each  drive codes: 00 stop, 01 forward, 10 reverse.
- `fsm_step`  out  1  one-cycle advance enable to the navigation FSM.
- `busy`  out  1  high while in RUN or DONE.
- `src`  out  1  owner of the current or last grant: 0 nav, 1 manual.
- `err`  out  1  one-cycle pulse when a nav command has TL and TR both set.

## Operation
- States:
  - IDLE: wheels 00, `busy` 0.
  - RUN: wheels driven from the latched command.
  - DONE: one cycle, wheels 00.
- IDLE → RUN when any request is sampled high.
  - On that edge: latch command, source, and step count; load the tick counter with 0; register the matching ack, which is high during the first RUN cycle.
- Arbitration (IDLE only):
  - Manual wins ties by default.
  - Starvation guard: a 2-bit counter `mcnt` increments on every manual grant made while `nav_req` is high, and clears on any nav grant.
  - When `mcnt` is 3 and both requesters are requesting, nav wins.
- Nav command decode:
  - F only: L 01, R 01, `FWD_STEPS`.
  - TL only: L 10, R 01, `TURN_STEPS`.
  - TR only: L 01, R 10, `TURN_STEPS`.
  - TL+F: L 00, R 01, `TURN_STEPS`.
  - TR+F: L 01, R 00, `TURN_STEPS`.
  - No bits set: stop for 1 step.
  - TL+TR (any F): stop for 1 step, and `err` pulses in the first RUN cycle.
- Manual decode:
  - 01: L 01, R 01, `FWD_STEPS`.
  - 10: L 10, R 01, `TURN_STEPS`.
  - 11: L 01, R 10, `TURN_STEPS`.
  - 00: stop for 1 step.
- RUN counting:
  - The tick counter counts 0..TICK_DIV-1.
  - On wrap, the step counter decrements.
  - RUN → DONE on the wrap of the last step.
- Manual-stop preemption:
  - Condition: in RUN with `src`=0, and `man_req`=1 with `man_cmd`=00.
  - Next edge → DONE: wheels go 00 and `fsm_step` is not pulsed. The manual stop is then granted from IDLE normally.
- DONE → IDLE unconditionally.
  - `fsm_step` is high during DONE only if `src`=0 and the run completed without preemption.
- Requests and commands are sampled only at the grant edge; input changes during RUN or DONE are ignored, except for the preemption check.
- A request dropped before its ack is treated as withdrawn; no grant is made.

## Timing
- Reset values: state IDLE; all counters 0; `mcnt` 0; `wheel_l`, `wheel_r` 00; `nav_ack`, `man_ack`, `fsm_step`, `busy`, `src`, `err` all 0.
- Reset mid-RUN: outputs reach reset values on the next edge, with no `fsm_step`.
- Request sampled in cycle t → ack and first wheel drive in cycle t+1.
- RUN lasts TICK_DIV×steps cycles. DONE is one cycle, then IDLE is one cycle.
- Back-to-back command spacing is TICK_DIV×steps+2 cycles, ack to ack.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Counter widths: `$clog2(TICK_DIV)` for the tick counter, and `$clog2(max(TURN_STEPS,FWD_STEPS)+1)` for the step counter.

## Test plan
- Reset then nav F, with TICK_DIV=4, FWD_STEPS=2, `nav_req` sampled in cycle 0 → `nav_ack` in cycle 1; wheels 01/01 in cycles 1–8; DONE with `fsm_step`=1 in cycle 9; IDLE in cycle 10.
- Nav TL+F, with TURN_STEPS=4 → wheels 00/01 for 16 cycles; `src`=0; a single `fsm_step`.
- Nav TL+TR → `err` pulse in the first RUN cycle; wheels 00/00 for 4 cycles; `fsm_step` still pulses.
- Both requesting continuously, manual cmd 01 → grants go man, man, man, nav, man…; `mcnt` returns to 0 after the nav grant.
- Nav TR in RUN; at tick 5 `man_req`=1 with `man_cmd`=00 → DONE next cycle, no `fsm_step`; `man_ack` follows 2 cycles later; wheels 00.
- Reset asserted mid-RUN (cycle 3 of 16) → all outputs at reset values on the next edge; the next `nav_req` is granted 1 cycle after reset is released.
